// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types for the unified memory arbiter: FSM state constants and
// the owner encoding of the current memory access.
package unified_mem_arbiter_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ISSUE = 2'd1;
    localparam state_t ST_WAIT  = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_e;

endpackage : unified_mem_arbiter_pkg

// File: rtl/unified_mem_arbiter.sv
// Arbitrates a single-port fixed-latency memory between instruction fetch and
// data access; data wins because it belongs to the older instruction.
module unified_mem_arbiter
    import unified_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              dm_read,
    input  logic              dm_write,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ready,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(MEM_LAT + 1);

    state_t            state_q,     state_d;
    owner_e            owner_q,     owner_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic              mem_en_q,    mem_en_d;
    logic              mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] if_rdata_q,  if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q,  dm_rdata_d;
    logic              if_ready_q,  if_ready_d;
    logic              dm_ready_q,  dm_ready_d;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves a latch behind.
        state_d     = state_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        mem_en_d    = 1'b0;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_ready_d  = 1'b0;
        dm_ready_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (dm_read || dm_write) begin
                    state_d     = ST_ISSUE;
                    owner_d     = OWN_DATA;
                    mem_en_d    = 1'b1;
                    mem_we_d    = dm_write;
                    mem_addr_d  = dm_addr;
                    mem_wdata_d = dm_wdata;
                end else if (if_req) begin
                    state_d    = ST_ISSUE;
                    owner_d    = OWN_INST;
                    mem_en_d   = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = if_addr;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
                cnt_d   = CNT_W'(MEM_LAT);
            end
            ST_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
                // Last wait cycle is exactly when the memory presents read data.
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = ST_DONE;
                    if (owner_q == OWN_DATA) begin
                        dm_ready_d = 1'b1;
                        if (!mem_we_q) begin
                            dm_rdata_d = mem_rdata;
                        end
                    end else begin
                        if_ready_d = 1'b1;
                        if_rdata_d = mem_rdata;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_INST;
            cnt_q       <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_ready_q  <= 1'b0;
            dm_ready_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values.
            state_q     <= state_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            if_ready_q  <= if_ready_d;
            dm_ready_q  <= dm_ready_d;
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign if_ready  = if_ready_q;
    assign dm_ready  = dm_ready_q;

    // Stalls are combinational so the pipeline freezes in the request cycle itself.
    assign stall_if  = if_req & ~if_ready_q;
    assign stall_mem = (dm_read | dm_write) & ~dm_ready_q;

endmodule : unified_mem_arbiter

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench: transaction-timeline reference model plus directed
// scenarios, random traffic, mid-access reset and a MEM_LAT=1 instance.
module tb_unified_mem_arbiter;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0, dm_read = 1'b0, dm_write = 1'b0;
    logic [31:0] if_addr = '0, dm_addr = '0, dm_wdata = '0, mem_rdata = '0;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
    logic        if_ready, dm_ready, stall_if, stall_mem, mem_en, mem_we;

    logic        b_if_req = 1'b0;
    logic [31:0] b_if_addr = '0, b_mem_rdata = '0;
    logic [31:0] b_if_rdata, b_dm_rdata, b_mem_addr, b_mem_wdata;
    logic        b_if_ready, b_dm_ready, b_stall_if, b_stall_mem, b_mem_en, b_mem_we;

    always #5 clk = ~clk;

    unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ready(dm_ready),
        .stall_if(stall_if), .stall_mem(stall_mem),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut_lat1 (
        .clk(clk), .rst(rst),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_rdata(b_if_rdata), .if_ready(b_if_ready),
        .dm_read(1'b0), .dm_write(1'b0), .dm_addr(32'h0), .dm_wdata(32'h0),
        .dm_rdata(b_dm_rdata), .dm_ready(b_dm_ready),
        .stall_if(b_stall_if), .stall_mem(b_stall_mem),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_rdata(b_mem_rdata)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    // Reference model: one access is a timeline anchored at its grant cycle g.
    int          cyc = 0;
    int          g   = 0;
    bit          busy = 0, own_data = 0, own_we = 0;
    logic [31:0] own_addr = '0, own_wdata = '0, sampled = '0;
    logic [31:0] e_if_rdata = '0, e_dm_rdata = '0;
    bit          prev_ifr = 0, prev_dmr = 0;

    int          en_q[$], ifr_q[$], dmr_q[$];
    logic [31:0] addr_q[$];

    // Staged inputs for directed mode.
    logic        s_if_req = 0, s_dm_read = 0, s_dm_write = 0;
    logic [31:0] s_if_addr = '0, s_dm_addr = '0, s_dm_wdata = '0, fixed_rdata = '0;

    task automatic clear_obs();
        en_q.delete(); ifr_q.delete(); dmr_q.delete(); addr_q.delete();
    endtask

    task automatic model_and_check();
        bit   done_now;
        logic e_en, e_ifr, e_dmr;
        done_now = 0;
        e_en  = busy && (cyc == g + 1);
        if (busy && cyc == g + 1 + LAT) sampled = mem_rdata;
        e_ifr = busy && (cyc == g + 2 + LAT) && !own_data;
        e_dmr = busy && (cyc == g + 2 + LAT) && own_data;
        if (busy && cyc == g + 2 + LAT) begin
            if (!own_we) begin
                if (own_data) e_dm_rdata = sampled;
                else          e_if_rdata = sampled;
            end
            busy     = 0;
            done_now = 1;
        end

        if (mem_en === 1'b1) begin en_q.push_back(cyc); addr_q.push_back(mem_addr); end
        if (if_ready === 1'b1) ifr_q.push_back(cyc);
        if (dm_ready === 1'b1) dmr_q.push_back(cyc);

        check("mem_en", {31'b0, mem_en}, {31'b0, e_en});
        check("if_ready", {31'b0, if_ready}, {31'b0, e_ifr});
        check("dm_ready", {31'b0, dm_ready}, {31'b0, e_dmr});
        check("if_rdata", if_rdata, e_if_rdata);
        check("dm_rdata", dm_rdata, e_dm_rdata);
        check("stall_if", {31'b0, stall_if}, {31'b0, if_req & ~e_ifr});
        check("stall_mem", {31'b0, stall_mem}, {31'b0, (dm_read | dm_write) & ~e_dmr});
        if (e_en) begin
            check("mem_addr", mem_addr, own_addr);
            check("mem_we", {31'b0, mem_we}, {31'b0, own_we});
            if (own_we) check("mem_wdata", mem_wdata, own_wdata);
        end
        prev_ifr = e_ifr;
        prev_dmr = e_dmr;

        if (!busy && !done_now) begin
            if (dm_read || dm_write) begin
                busy = 1; g = cyc; own_data = 1; own_we = dm_write;
                own_addr = dm_addr; own_wdata = dm_wdata;
            end else if (if_req) begin
                busy = 1; g = cyc; own_data = 0; own_we = 0; own_addr = if_addr;
            end
        end
    endtask

    task automatic rand_drive();
        if (if_req) begin
            if (prev_ifr) begin
                if_req  = 1'($urandom_range(0, 1));
                if_addr = $urandom & 32'hFFFF_FFFC;
            end else if ($urandom_range(0, 31) == 0) begin
                if_req = 1'b0;
            end
        end else if ($urandom_range(0, 2) == 0) begin
            if_req  = 1'b1;
            if_addr = $urandom & 32'hFFFF_FFFC;
        end
        if (dm_read || dm_write) begin
            if (prev_dmr || $urandom_range(0, 31) == 0) begin
                dm_read = 1'b0; dm_write = 1'b0;
            end
        end else if ($urandom_range(0, 2) == 0) begin
            dm_write = 1'($urandom_range(0, 1));
            dm_read  = ~dm_write;
            dm_addr  = $urandom & 32'hFFFF_FFFC;
            dm_wdata = $urandom;
        end
        mem_rdata = $urandom;
    endtask

    // One cycle: drive just after the rising edge, check on the falling edge.
    task automatic step(input bit rnd);
        @(posedge clk);
        #1;
        cyc++;
        if (rnd) begin
            rand_drive();
        end else begin
            if (prev_ifr) s_if_req = 1'b0;
            if (prev_dmr) begin s_dm_read = 1'b0; s_dm_write = 1'b0; end
            if_req = s_if_req;     if_addr = s_if_addr;
            dm_read = s_dm_read;   dm_write = s_dm_write;
            dm_addr = s_dm_addr;   dm_wdata = s_dm_wdata;
            mem_rdata = fixed_rdata;
        end
        @(negedge clk);
        model_and_check();
    endtask

    initial begin
        int          t;
        int          en_j, rdy_j;
        logic [31:0] saved, en_addr, rdy_data;

        #1;
        check("rst_mem_en", {31'b0, mem_en}, 32'h0);
        check("rst_mem_we", {31'b0, mem_we}, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_if_rdata", if_rdata, 32'h0);
        check("rst_dm_rdata", dm_rdata, 32'h0);
        check("rst_readies", {30'b0, if_ready, dm_ready}, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Fetch only; requester holds through ready and drops next cycle.
        clear_obs();
        s_if_req = 1; s_if_addr = 32'h40; fixed_rdata = 32'h2008_000A;
        step(0); t = cyc;
        repeat (7) step(0);
        check("f_en_count", en_q.size(), 1);
        check("f_en_cyc", en_q[0] - t, 1);
        check("f_en_addr", addr_q[0], 32'h40);
        check("f_rdy_count", ifr_q.size(), 1);
        check("f_rdy_cyc", ifr_q[0] - t, 4);
        check("f_rdata", if_rdata, 32'h2008_000A);

        // Store: dm_rdata must not change.
        clear_obs();
        saved = e_dm_rdata;
        s_dm_write = 1; s_dm_addr = 32'h100; s_dm_wdata = 32'hDEAD_BEEF; fixed_rdata = 32'h5555_AAAA;
        step(0); t = cyc;
        repeat (6) step(0);
        check("s_en_cyc", en_q[0] - t, 1);
        check("s_rdy_cyc", dmr_q[0] - t, 4);
        check("s_rdata_held", dm_rdata, saved);

        // Simultaneous fetch and load: data first.
        clear_obs();
        s_if_req = 1; s_if_addr = 32'h44; s_dm_read = 1; s_dm_addr = 32'h200;
        fixed_rdata = 32'h0BAD_F00D;
        step(0); t = cyc;
        repeat (11) step(0);
        check("sim_en_count", en_q.size(), 2);
        check("sim_en0_cyc", en_q[0] - t, 1);
        check("sim_en0_addr", addr_q[0], 32'h200);
        check("sim_dm_rdy", dmr_q[0] - t, 4);
        check("sim_en1_cyc", en_q[1] - t, 6);
        check("sim_en1_addr", addr_q[1], 32'h44);
        check("sim_if_rdy", ifr_q[0] - t, 9);

        // Random traffic, then drain.
        repeat (1500) step(1);
        s_if_req = if_req; s_if_addr = if_addr;
        s_dm_read = dm_read; s_dm_write = dm_write; s_dm_addr = dm_addr; s_dm_wdata = dm_wdata;
        repeat (15) step(0);

        // Reset while in WAIT.
        clear_obs();
        s_if_req = 1; s_if_addr = 32'h80; fixed_rdata = 32'h1357_9BDF;
        step(0); step(0); step(0);
        #2 rst = 1'b1;
        #1;
        check("arst_mem_en", {31'b0, mem_en}, 32'h0);
        check("arst_regs", mem_addr | if_rdata | dm_rdata | mem_wdata, 32'h0);
        check("arst_flags", {29'b0, mem_we, if_ready, dm_ready}, 32'h0);
        check("arst_stall_if", {31'b0, stall_if}, 32'h1);
        if_req = 1'b0; s_if_req = 0;
        busy = 0; prev_ifr = 0; prev_dmr = 0; e_if_rdata = '0; e_dm_rdata = '0;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (6) step(0);
        check("arst_no_ready", ifr_q.size(), 0);
        clear_obs();
        s_if_req = 1; s_if_addr = 32'h84; fixed_rdata = 32'h2468_ACE0;
        step(0); t = cyc;
        repeat (6) step(0);
        check("arst_new_rdy", ifr_q[0] - t, 4);
        check("arst_new_data", if_rdata, 32'h2468_ACE0);

        // MEM_LAT=1 instance: mem_en at t+1, if_ready at t+3.
        en_j = -1; rdy_j = -1; en_addr = '0; rdy_data = '0;
        @(posedge clk);
        #1 b_if_req = 1'b1; b_if_addr = 32'h90; b_mem_rdata = 32'hCAFE_0001;
        for (int j = 0; j < 7; j++) begin
            @(negedge clk);
            if (b_mem_en === 1'b1 && en_j < 0) begin en_j = j; en_addr = b_mem_addr; end
            if (b_if_ready === 1'b1 && rdy_j < 0) begin rdy_j = j; rdy_data = b_if_rdata; end
            @(posedge clk);
            #1;
            if (rdy_j >= 0) b_if_req = 1'b0;
        end
        check("l1_en_cyc", en_j, 1);
        check("l1_en_addr", en_addr, 32'h90);
        check("l1_rdy_cyc", rdy_j, 3);
        check("l1_rdata", rdy_data, 32'hCAFE_0001);
        check("l1_idle", {27'b0, b_dm_ready, b_stall_mem, b_mem_we, b_stall_if, b_mem_en}, 32'h0);
        check("l1_dm_side", b_dm_rdata | b_mem_wdata, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_unified_mem_arbiter
